// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron operand stream: vector geometry, the
// signed data / weight / bias types, the slot index type and the operand
// feeder FSM state encoding.
// -----------------------------------------------------------------------------
package neuron_pkg;

    localparam int NEURON_WIDTH = 10;  // (data, weight) pairs per vector
    localparam int NEURON_BITS  = 15;  // data is NEURON_BITS+1 bits, signed
    localparam int W_BITS       = 32;  // weight width, signed
    localparam int B_BITS       = 15;  // bias is B_BITS+1 bits, signed
    localparam int IDX_BITS     = $clog2(NEURON_WIDTH);

    typedef logic signed [NEURON_BITS:0] data_t;
    typedef logic signed [W_BITS-1:0]    weight_t;
    typedef logic signed [B_BITS:0]      bias_t;
    typedef logic        [IDX_BITS-1:0]  idx_t;

    // One extra bit so the slot count is representable even when
    // NEURON_WIDTH is a power of two.
    localparam logic [IDX_BITS:0] SLOT_COUNT = (IDX_BITS+1)'(NEURON_WIDTH);
    localparam idx_t              LAST_IDX   = idx_t'(NEURON_WIDTH-1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_BIAS   = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    // Bias travels on the data lane; the signed cast sign-extends.
    function automatic data_t bias_to_data(input bias_t b);
        return data_t'(b);
    endfunction

    function automatic logic slot_in_range(input idx_t a);
        return ({1'b0, a} < SLOT_COUNT);
    endfunction

endpackage

// File: rtl/neuron_operand_buffer.sv
// -----------------------------------------------------------------------------
// neuron_operand_buffer
// NEURON_WIDTH-entry register file holding one input vector and its weights.
// One synchronous write port, one asynchronous read port, asynchronously
// cleared to zero.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low clear
//   we                  write strobe (out-of-range addresses are dropped)
//   wr_addr/data/weight write slot and contents
//   rd_addr             read slot
//   rd_data, rd_weight  contents of rd_addr (0 when out of range)
// -----------------------------------------------------------------------------
module neuron_operand_buffer
    import neuron_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    we,
    input  idx_t    wr_addr,
    input  data_t   wr_data,
    input  weight_t wr_weight,
    input  idx_t    rd_addr,
    output data_t   rd_data,
    output weight_t rd_weight
);

    data_t   data_q   [NEURON_WIDTH];
    weight_t weight_q [NEURON_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NEURON_WIDTH; i++) begin
                data_q[i]   <= '0;
                weight_q[i] <= '0;
            end
        end else if (we && slot_in_range(wr_addr)) begin
            data_q[wr_addr]   <= wr_data;
            weight_q[wr_addr] <= wr_weight;
        end
    end

    always_comb begin
        rd_data   = '0;
        rd_weight = '0;
        if (slot_in_range(rd_addr)) begin
            rd_data   = data_q[rd_addr];
            rd_weight = weight_q[rd_addr];
        end
    end

endmodule

// File: rtl/neuron_operand_feeder.sv
// -----------------------------------------------------------------------------
// neuron_operand_feeder
// Transmit side of the neuron operand stream. Holds one vector, its weights
// and a bias; on start it streams (data, weight) pairs one per transfer and
// then one bias beat, then pulses done.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_weight   buffer write (accepted only in IDLE)
//   bias_in                       bias, latched on accepted start
//   start                         begin streaming (accepted only in IDLE)
//   busy                          high while streaming pairs or bias
//   done                          one-cycle pulse after the bias transfer
//   out_valid/out_ready           stream handshake
//   out_data/out_weight/out_index operand, weight, slot (bias / 0 / 0 on bias beat)
//   out_bias, out_last            mark the bias beat
//
// Build option: NEURON_FEEDER_SKIP_ZERO_EN -- slots whose data is zero are
// not presented; each still costs one cycle with out_valid low.
// -----------------------------------------------------------------------------
module neuron_operand_feeder
    import neuron_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    wr_en,
    input  idx_t    wr_addr,
    input  data_t   wr_data,
    input  weight_t wr_weight,
    input  bias_t   bias_in,
    input  logic    start,
    output logic    busy,
    output logic    done,
    output logic    out_valid,
    input  logic    out_ready,
    output data_t   out_data,
    output weight_t out_weight,
    output idx_t    out_index,
    output logic    out_bias,
    output logic    out_last
);

    feeder_state_t state_q, state_d;
    idx_t          idx_q, idx_d;
    bias_t         bias_q, bias_d;

    data_t   rd_data;
    weight_t rd_weight;
    logic    buf_we;
    logic    slot_skip;
    logic    xfer;

    // Writes only land while idle; a same-cycle start takes priority.
    assign buf_we = (state_q == ST_IDLE) && wr_en && !start;

    neuron_operand_buffer u_buffer (
        .clk       (clk),
        .rstn      (rstn),
        .we        (buf_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_weight (wr_weight),
        .rd_addr   (idx_q),
        .rd_data   (rd_data),
        .rd_weight (rd_weight)
    );

`ifdef NEURON_FEEDER_SKIP_ZERO_EN
    assign slot_skip = (state_q == ST_STREAM) && (rd_data == '0);
`else
    assign slot_skip = 1'b0;
`endif

    // Handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high. out_valid and every out_* field come only from
    // registered state and the buffer (which cannot be written while busy), so
    // they are independent of out_ready and stay frozen while stalled, and
    // out_valid only falls after the beat it qualifies has transferred.
    assign out_valid = ((state_q == ST_STREAM) && !slot_skip) || (state_q == ST_BIAS);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bias_d  = bias_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    bias_d  = bias_in;
                end
            end
            ST_STREAM: begin
                // A skipped slot advances exactly like a transferred one.
                if (xfer || slot_skip) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_BIAS;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            ST_BIAS: begin
                if (xfer) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bias_q  <= bias_d;
        end
    end

    always_comb begin
        out_data   = '0;
        out_weight = '0;
        out_index  = '0;
        case (state_q)
            ST_STREAM: begin
                out_data   = rd_data;
                out_weight = rd_weight;
                out_index  = idx_q;
            end
            ST_BIAS: begin
                out_data = bias_to_data(bias_q);
            end
            default: begin
                out_data   = '0;
                out_weight = '0;
                out_index  = '0;
            end
        endcase
    end

    assign out_bias = (state_q == ST_BIAS);
    assign out_last = (state_q == ST_BIAS);
    assign busy     = (state_q == ST_STREAM) || (state_q == ST_BIAS);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_neuron_operand_feeder.sv
module tb_neuron_operand_feeder;
    import neuron_pkg::*;

    localparam int BW = 2 + IDX_BITS + W_BITS + NEURON_BITS + 1;

    // ---------------- clock / reset / DUT ----------------
    logic    clk = 1'b0;
    logic    rstn;
    logic    wr_en;
    idx_t    wr_addr;
    data_t   wr_data;
    weight_t wr_weight;
    bias_t   bias_in;
    logic    start;
    logic    busy, done, out_valid, out_ready;
    data_t   out_data;
    weight_t out_weight;
    idx_t    out_index;
    logic    out_bias, out_last;

    always #5 clk = ~clk;

    neuron_operand_feeder dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_weight  (wr_weight),
        .bias_in    (bias_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_weight (out_weight),
        .out_index  (out_index),
        .out_bias   (out_bias),
        .out_last   (out_last)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [BW-1:0] exp_q[$];

    data_t   m_data   [NEURON_WIDTH];
    weight_t m_weight [NEURON_WIDTH];

    data_t v_data [NEURON_WIDTH] = '{-16'sd2, 16'sd5, -16'sd1, 16'sd10, 16'sd3,
                                     -16'sd4, 16'sd7, -16'sd6, 16'sd2, 16'sd8};
    weight_t v_weight [NEURON_WIDTH] = '{32'sd3, 32'sd2, 32'sd8, 32'sd10, 32'sd1,
                                         32'sd2, 32'sd4, 32'sd3, 32'sd5, 32'sd2};

    function automatic logic [BW-1:0] pack(input logic b, input logic l, input idx_t i,
                                           input weight_t w, input data_t d);
        return {b, l, i, w, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic write_slot(input idx_t a, input data_t d, input weight_t w);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_weight = w;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < NEURON_WIDTH) begin
            m_data[a]   = d;
            m_weight[a] = w;
        end
    endtask

    task automatic load_vector();
        for (int i = 0; i < NEURON_WIDTH; i++) write_slot(idx_t'(i), v_data[i], v_weight[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},  out_valid,  0);
        check({tag, "_busy"},   busy,       0);
        check({tag, "_done"},   done,       0);
        check({tag, "_data"},   out_data,   0);
        check({tag, "_weight"}, out_weight, 0);
        check({tag, "_index"},  out_index,  0);
        check({tag, "_bias"},   out_bias,   0);
        check({tag, "_last"},   out_last,   0);
    endtask

    // mode 0: plain run; 1: start + write slot 0 while busy;
    // 2: write slot 0 = 77 in the same cycle as start.
    // pat 0: out_ready always 1; pat 1: out_ready 1,0,0,1,0,0,...
    task automatic run_vector(input string tag, input int pat, input bias_t bias,
                              input int exp_sum, input int mode);
        int sum, cycles, stalls, beats;
        logic finished, have_held, rdy;
        logic [BW-1:0] held, cur, expb;
        exp_q.delete();
        for (int i = 0; i < NEURON_WIDTH; i++) begin
`ifdef NEURON_FEEDER_SKIP_ZERO_EN
            if (m_data[i] != 0)
`endif
            exp_q.push_back(pack(1'b0, 1'b0, idx_t'(i), m_weight[i], m_data[i]));
        end
        exp_q.push_back(pack(1'b1, 1'b1, '0, '0, data_t'(bias)));

        start = 1'b1; bias_in = bias;
        if (mode == 2) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = 16'sd77; wr_weight = 32'sd9;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; bias_in = '0;

        sum = 0; cycles = 0; stalls = 0; beats = 0;
        finished = 1'b0; have_held = 1'b0; held = '0;
        while (!finished && cycles < 100) begin
            rdy = (pat == 0) ? 1'b1 : ((cycles % 3) == 0);
            out_ready = rdy;
            start = (mode == 1 && cycles == 3);
            wr_en = (mode == 1 && cycles == 3);
            wr_addr = '0; wr_data = 16'sd99; wr_weight = 32'sd5;
            @(negedge clk);
            cycles++;
            check({tag, "_busy"}, busy, 1);
            if (have_held) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_hold"}, pack(out_bias, out_last, out_index, out_weight, out_data), held);
            end
            if (out_valid) begin
                cur = pack(out_bias, out_last, out_index, out_weight, out_data);
                if (rdy) begin
                    have_held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_beat"}, cur, '0);
                        finished = 1'b1;
                    end else begin
                        expb = exp_q.pop_front();
                        check($sformatf("%s_beat%0d", tag, beats), cur, expb);
                        beats++;
                        if (out_bias) sum += int'(out_data);
                        else          sum += int'(out_data) * int'(out_weight);
                        if (out_last) finished = 1'b1;
                    end
                end else begin
                    stalls++;
                    held = cur;
                    have_held = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; wr_en = 1'b0;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cycles"}, cycles, 11 + stalls);
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_valid"}, out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_done"}, done, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_weight = '0;
        bias_in = '0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NEURON_WIDTH; i++) begin m_data[i] = '0; m_weight[i] = '0; end

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Load vector; an out-of-range write must be dropped.
        load_vector();
        write_slot(idx_t'(10), 16'sd1234, 32'sd1234);
        @(negedge clk);
        check_idle_outputs("idle_after_load");
        @(posedge clk); #1;

        run_vector("full", 0, 16'sd5, 132, 0);
        run_vector("stall", 1, 16'sd5, 132, 0);
        run_vector("poke_busy", 0, 16'sd5, 132, 1);
        run_vector("after_poke", 0, 16'sd5, 132, 0);

        // Same-cycle start + write: write dropped, later idle write lands.
        run_vector("start_wins", 0, 16'sd5, 132, 2);
        write_slot('0, 16'sd77, 32'sd3);
        run_vector("slot0_77", 0, 16'sd5, 369, 0);

        // Reset mid-stream after the 4th transfer.
        start = 1'b1; bias_in = 16'sd5; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_index", out_index, 4);
        check("mid_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        check_idle_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        for (int i = 0; i < NEURON_WIDTH; i++) begin m_data[i] = '0; m_weight[i] = '0; end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_done", done, 0);
        check("post_reset_busy", busy, 0);
        @(posedge clk); #1;
        load_vector();
        run_vector("reloaded", 0, 16'sd5, 132, 0);

`ifdef NEURON_FEEDER_SKIP_ZERO_EN
        for (int i = 0; i < NEURON_WIDTH; i++) write_slot(idx_t'(i), '0, 32'sd1);
        write_slot(idx_t'(1), 16'sd3, 32'sd1);
        write_slot(idx_t'(9), 16'sd4, 32'sd1);
        run_vector("skip_zero", 0, '0, 7, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
